// File: rtl/dct_col_stage_2.sv
// Column-pass 8-point 1-D DCT: captures one column on start, emits X[0..7] one per enabled cycle.
// Define DCT_COL_SAT_EN to saturate results to SIZE_OUT bits; otherwise they wrap.
module dct_col_stage_2 #(
  parameter int SIZE        = 10,
  parameter int APPROX_BITS = 8,
  parameter int SIZE_MULT   = SIZE + 6,
  parameter int SIZE_OUT    = SIZE + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SIZE-1:0]     data_in [8],
  input  logic                       start,
  input  logic                       wr_en,
  input  logic                       approx_en,
  output logic signed [SIZE_OUT-1:0] data_out [8],
  output logic                       done
);

  // Eight products summed need three guard bits above the product width.
  localparam int ACC_W = SIZE_MULT + 3;
  localparam logic signed [SIZE_MULT-1:0] APPROX_MASK =
    ~((SIZE_MULT'(1) << APPROX_BITS) - SIZE_MULT'(1));

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 k_q, k_d;
  logic                       done_q, done_d;
  logic                       step;
  logic signed [SIZE-1:0]     x_q   [8];
  logic signed [SIZE_OUT-1:0] out_q [8];

  logic signed [6:0]          c;
  logic signed [SIZE_MULT-1:0] xe, ce, p;
  logic signed [ACC_W-1:0]    acc, y_full;
  logic signed [SIZE_OUT-1:0] y;

  // C[k][n]: phase index m = (2n+1)k mod 32 folded onto the first quadrant of cos(m*pi/16).
  function automatic logic signed [6:0] coef(input logic [2:0] k, input logic [2:0] n);
    logic [4:0]        m;
    logic [2:0]        idx;
    logic signed [6:0] mag;
    m   = {1'b0, n, 1'b1} * {2'b00, k};
    idx = m[3] ? (~m[2:0] + 3'd1) : m[2:0];
    case (idx)
      3'd1:    mag = 7'sd63;
      3'd2:    mag = 7'sd59;
      3'd3:    mag = 7'sd53;
      3'd4:    mag = 7'sd45;
      3'd5:    mag = 7'sd36;
      3'd6:    mag = 7'sd24;
      3'd7:    mag = 7'sd12;
      default: mag = 7'sd0;
    endcase
    if (k == 3'd0) return 7'sd45;
    return (m[4] ^ m[3]) ? -mag : mag;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) out_q[i] <= '0;
    end else begin
      // NOTE: registers take <= so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      if (step) out_q[k_q] <= y;
    end
  end

  // NOTE: sample registers carry no reset; they are always loaded by start before being read.
  always_ff @(posedge clk) begin
    if (start) x_q <= data_in;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (start) begin
      state_d = BUSY;
      k_d     = '0;
    end else if (state_q == BUSY && wr_en) begin
      k_d = k_q + 3'd1;
      if (k_q == 3'd7) state_d = IDLE;
    end
  end

  // A start on the same edge as a write wins: no write and no done.
  always_comb begin
    step   = (state_q == BUSY) && wr_en && !start;
    done_d = step && (k_q == 3'd7);
  end

  always_comb begin
    acc = '0;
    c   = '0;
    xe  = '0;
    ce  = '0;
    p   = '0;
    for (int n = 0; n < 8; n++) begin
      c  = coef(k_q, 3'(n));
      xe = {{(SIZE_MULT-SIZE){x_q[n][SIZE-1]}}, x_q[n]};
      ce = {{(SIZE_MULT-7){c[6]}}, c};
      p  = xe * ce;
      if (approx_en) p = p & APPROX_MASK;
      acc = acc + {{(ACC_W-SIZE_MULT){p[SIZE_MULT-1]}}, p};
    end
    y_full = (acc + ACC_W'(64)) >>> 7;
  end

`ifdef DCT_COL_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((2 ** (SIZE_OUT - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(-(2 ** (SIZE_OUT - 1)));

  always_comb begin
    if (y_full > Y_MAX)      y = Y_MAX[SIZE_OUT-1:0];
    else if (y_full < Y_MIN) y = Y_MIN[SIZE_OUT-1:0];
    else                     y = SIZE_OUT'(y_full);
  end
`else
  assign y = SIZE_OUT'(y_full);
`endif

  assign data_out = out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dct_col_stage_2.sv
// Scoreboard bench for dct_col_stage_2: a real-valued cosine model predicts each coefficient write.
module tb_dct_col_stage_2;

  localparam int  SIZE        = 10;
  localparam int  SIZE_OUT    = 12;
  localparam int  APPROX_BITS = 8;
  localparam real PI          = 3.14159265358979;

  logic                       clk = 1'b0;
  logic                       rst, start, wr_en, approx_en, done;
  logic signed [SIZE-1:0]     data_in  [8];
  logic signed [SIZE_OUT-1:0] data_out [8];

  always #5 clk = ~clk;

  dct_col_stage_2 dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .start    (start),
    .wr_en    (wr_en),
    .approx_en(approx_en),
    .data_out (data_out),
    .done     (done)
  );

  typedef struct {int k; int val;} exp_t;
  exp_t sb[$];
  int   cur_x [8];
  int   mdl_out [8];
  int   k_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mcoef(input int k, input int n);
    real ck;
    ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
    return int'(128.0 * (ck / 2.0) * $cos(real'((2 * n + 1) * k) * PI / 16.0));
  endfunction

  function automatic int model(input int k, input bit apx);
    int acc, p;
    acc = 0;
    for (int n = 0; n < 8; n++) begin
      p = cur_x[n] * mcoef(k, n);
      if (apx) p = p & ~((1 << APPROX_BITS) - 1);
      acc += p;
    end
    return (acc + 64) >>> 7;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int xs[8]);
    for (int i = 0; i < 8; i++) begin
      cur_x[i]   = xs[i];
      data_in[i] = SIZE'(xs[i]);
    end
    start = 1'b1;
    wr_en = 1'b0;
    tick();
    start = 1'b0;
    k_exp = 0;
  endtask

  task automatic step(input bit apx, input string tag);
    exp_t e;
    approx_en = apx;
    wr_en     = 1'b1;
    e.k   = k_exp;
    e.val = model(k_exp, apx);
    sb.push_back(e);
    k_exp++;
    tick();
    e = sb.pop_front();
    mdl_out[e.k] = e.val;
    check($sformatf("%s X%0d", tag, e.k), int'(data_out[e.k]), e.val);
    check($sformatf("%s done@X%0d", tag, e.k), int'(done), int'(e.k == 7));
  endtask

  task automatic finish_run(input string tag);
    wr_en = 1'b0;
    tick();
    check({tag, " done_pulse_end"}, int'(done), 0);
  endtask

  task automatic run(input int xs[8], input bit apx, input string tag);
    capture(xs);
    for (int i = 0; i < 8; i++) step(apx, tag);
    finish_run(tag);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s out%0d", tag, i), int'(data_out[i]), mdl_out[i]);
  endtask

  task automatic rand_vec(output int xs[8]);
    for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 1023)) - 512;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a[8], b[8];
    int imp_exp[8] = '{90, 126, 118, 106, 90, 72, 48, 24};

    rst = 1'b1; start = 1'b0; wr_en = 1'b0; approx_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in[i] = '0;
      mdl_out[i] = 0;
    end
    tick();
    tick();
    check_all("reset");
    check("reset done", int'(done), 0);
    rst = 1'b0;

    a = '{default: 100};
    run(a, 1'b0, "dc100");
    check("spec dc100 X0", int'(data_out[0]), 281);

    a = '{256, 0, 0, 0, 0, 0, 0, 0};
    run(a, 1'b0, "impulse");
    for (int i = 0; i < 8; i++)
      check($sformatf("spec impulse X%0d", i), int'(data_out[i]), imp_exp[i]);

    a = '{default: -512};
    run(a, 1'b0, "neg512");
    check("spec neg512 X0", int'(data_out[0]), -1440);
    a = '{default: 511};
    run(a, 1'b0, "pos511");
    check("spec pos511 X0", int'(data_out[0]), 1437);

    a = '{100, 0, 0, 0, 0, 0, 0, 0};
    run(a, 1'b1, "approx1");
    check("spec approx1 X0", int'(data_out[0]), 34);
    run(a, 1'b0, "approx0");
    check("spec approx0 X0", int'(data_out[0]), 35);

    for (int t = 0; t < 3; t++) begin
      rand_vec(a);
      capture(a);
      for (int i = 0; i < 8; i++) step(1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
      finish_run($sformatf("rand%0d", t));
    end

    // Stall three cycles after the X[2] write.
    rand_vec(a);
    capture(a);
    for (int i = 0; i < 3; i++) step(1'b0, "stall");
    wr_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("stall hold%0d done", s), int'(done), 0);
      check($sformatf("stall hold%0d out2", s), int'(data_out[2]), mdl_out[2]);
      check($sformatf("stall hold%0d out3", s), int'(data_out[3]), mdl_out[3]);
    end
    for (int i = 0; i < 5; i++) step(1'b0, "stall");
    finish_run("stall");

    // Reset at k=4, then wr_en in IDLE must be ignored.
    rand_vec(a);
    capture(a);
    for (int i = 0; i < 4; i++) step(1'b0, "abort");
    rst   = 1'b1;
    wr_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) mdl_out[i] = 0;
    check_all("abort reset");
    check("abort reset done", int'(done), 0);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick();
      check($sformatf("abort idle%0d done", s), int'(done), 0);
      check($sformatf("abort idle%0d out0", s), int'(data_out[0]), 0);
    end
    rand_vec(a);
    run(a, 1'b0, "after_abort");

    // Start collides with the X[7] write: recapture wins.
    rand_vec(a);
    capture(a);
    for (int i = 0; i < 7; i++) step(1'b0, "clash_old");
    rand_vec(b);
    for (int i = 0; i < 8; i++) data_in[i] = SIZE'(b[i]);
    start = 1'b1;
    wr_en = 1'b1;
    tick();
    check("clash done", int'(done), 0);
    check("clash out7 held", int'(data_out[7]), mdl_out[7]);
    start = 1'b0;
    for (int i = 0; i < 8; i++) cur_x[i] = b[i];
    k_exp = 0;
    for (int i = 0; i < 8; i++) step(1'b0, "clash_new");
    finish_run("clash_new");

    check("scoreboard empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_col_stage_2.md
# dct_col_stage_2

Second-pass (column) 8-point 1-D DCT engine for the JPEG DCT datapath. `dct_stage2` instantiates eight copies, one per column, all driven by a shared start and write-enable. Each copy captures one 8-sample column and produces the 8 DCT coefficients sequentially, one per enabled cycle. It raises a one-cycle done pulse after the last coefficient is written.

## Interface
Parameters:
- `SIZE`, 10: signed input sample width.
- `APPROX_BITS`, 8: number of product LSBs cleared in approximate mode.
- `SIZE_MULT`, SIZE+6: signed product width.
- `SIZE_OUT`, SIZE+2: signed output coefficient width.

Ports:
- `clk`, in, 1: single clock, all state updates on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_in[7:0]`, in, 8×SIZE signed: column samples x[0..7].
- `start`, in, 1: capture `data_in` and begin a new transform.
- `wr_en`, in, 1: advance/write enable. The parent sets it the cycle after `start` and clears it after `done`.
- `approx_en`, in, 1: selects approximate products. Sampled every compute cycle.
- `data_out[7:0]`, out, 8×SIZE_OUT signed: coefficient registers X[0..7].
- `done`, out, 1: one-cycle completion pulse.

## Operation
- Coefficient ROM: C[k][n] = round(128·(c(k)/2)·cos((2n+1)kπ/16)), with c(0)=1/√2 and c(k>0)=1. All coefficients are 7-bit signed.
  - Magnitudes: k=0 gives 45. For k>0, the value is indexed by m = ((2n+1)k mod 32), folded to cos(mπ/16), giving 63, 59, 53, 45, 36, 24, 12 for m=1..7 (before folding and sign).
- States:
  - IDLE: not busy.
  - BUSY: index k = 0..7.
- Capture: on `start`, latch all 8 `data_in` words, set k=0 and enter BUSY. This happens regardless of current state, so a `start` while BUSY restarts the transform and discards partial results.
- Compute step (BUSY && `wr_en`):
  - p[n] = x[n]·C[k][n], SIZE_MULT bits.
  - If `approx_en`: p[n] &= ~((1<<APPROX_BITS)-1), i.e. truncate toward −∞.
  - acc = Σ p[n], at least SIZE+9 bits, no overflow.
  - y = (acc + 64) >>> 7, arithmetic shift.
  - Write y into `data_out[k]`, then k++.
  - After k=7 is written, return to IDLE.
- BUSY with `wr_en`=0: stall. k, captured data and outputs are held.
- IDLE: `data_out` holds its last values, and `wr_en` is ignored.

## Timing
- Reset values: `data_out[*]`=0, `done`=0, state IDLE, k=0. `rst` has priority over `start`.
- Capture happens at edge E0, where `start` is sampled high.
- X[k] is written at the (k+1)-th subsequent edge with BUSY && `wr_en`. With `wr_en` continuously high, that is E1..E8.
- `done` is registered. It goes high at the edge that writes X[7] (E8) and low at the next edge. Exactly one cycle per transform.
- Latency from `start` to `done`: 8 cycles without stalls.
- Simultaneous `start` and last write: `start` wins. Data is recaptured, no X[7] write, no `done`.
- Reset mid-transform: immediate return to reset values. No `done`.

## Configuration
- `DCT_COL_SAT_EN` defined: y is saturated to [−2^(SIZE_OUT−1), 2^(SIZE_OUT−1)−1] before the write.
- `DCT_COL_SAT_EN` undefined: y is truncated to its low SIZE_OUT bits (wraps).
- For default SIZE=10 the two builds are identical, because |y| ≤ 1440 for all inputs.

## Test plan
- Reset, then all x=100, `start`, `wr_en` high from next cycle → X = {281,0,0,0,0,0,0,0}. `done` high exactly 8 cycles after `start`, for one cycle.
- Impulse x[0]=256, others 0 → X = {90,126,118,106,90,72,48,24}.
- All x=−512 → X[0]=−1440, X[1..7]=0. All x=511 → X[0]=1437.
- x[0]=100, others 0, `approx_en`=1 → X[0]=34. With `approx_en`=0 → X[0]=35.
- Drop `wr_en` for 3 cycles after the X[2] write → k and outputs hold, and `done` is delayed by 3 cycles.
- Assert `rst` at k=4, then issue a new `start` → outputs are 0 after reset, no `done` from the aborted run, and the new transform completes normally.
